// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : MEM/WB pipeline register with writeback mux, halt FSM and a
//             saturating retired-instruction counter.
//  Revision : 1.0  initial release
// ============================================================================
module wb_stage #(
    parameter logic ZERO_REG_WRITE_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic [3:0]  mem_dst_reg,
    input  logic        mem_to_reg,
    input  logic        mem_is_pcs,
    input  logic [15:0] mem_alu_result,
    input  logic [15:0] mem_read_data,
    input  logic [15:0] mem_pc_next,
    input  logic        mem_halt,
    output logic        WriteReg,
    output logic [3:0]  DstReg,
    output logic [15:0] DstData,
    output logic        wb_valid,
    output logic        halted,
    output logic [15:0] retired
);

    localparam logic [0:0] c_RUN    = 1'b0;
    localparam logic [0:0] c_HALTED = 1'b1;

    logic [0:0]  r_state;
    logic        r_valid;
    logic        r_regWrite;
    logic [3:0]  r_dstReg;
    logic        r_memToReg;
    logic        r_isPcs;
    logic [15:0] r_aluResult;
    logic [15:0] r_readData;
    logic [15:0] r_pcNext;
    logic        r_halt;
    logic [15:0] r_retired;

    logic w_run;
    logic w_haltNow;
    logic w_retireNow;

    assign w_run       = (r_state == c_RUN);
    assign w_haltNow   = w_run & r_valid & r_halt & ~stall;
    assign w_retireNow = w_run & r_valid & ~r_halt & ~stall & (r_retired != 16'hFFFF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_RUN;
            r_valid     <= 1'b0;
            r_regWrite  <= 1'b0;
            r_dstReg    <= 4'd0;
            r_memToReg  <= 1'b0;
            r_isPcs     <= 1'b0;
            r_aluResult <= 16'd0;
            r_readData  <= 16'd0;
            r_pcNext    <= 16'd0;
            r_halt      <= 1'b0;
            r_retired   <= 16'd0;
        end else if (w_run) begin
            if (w_retireNow) begin
                r_retired <= r_retired + 16'd1;
            end
            if (w_haltNow) begin
                r_state <= c_HALTED;
            end
            // The HLT stays resident in the register once it has retired.
            if (flush) begin
                r_valid <= 1'b0;
            end else if (!stall && !w_haltNow) begin
                r_valid     <= mem_valid;
                r_regWrite  <= mem_reg_write;
                r_dstReg    <= mem_dst_reg;
                r_memToReg  <= mem_to_reg;
                r_isPcs     <= mem_is_pcs;
                r_aluResult <= mem_alu_result;
                r_readData  <= mem_read_data;
                r_pcNext    <= mem_pc_next;
                r_halt      <= mem_halt & mem_valid;
            end
        end
    end

    always_comb begin
        DstData = r_aluResult;
        if (r_memToReg) begin
            DstData = r_readData;
        end else if (r_isPcs) begin
            DstData = r_pcNext;
        end
    end

    assign WriteReg = r_valid & r_regWrite & w_run & ~r_halt
                    & ((r_dstReg != 4'd0) | ZERO_REG_WRITE_EN);
    assign DstReg   = r_dstReg;
    assign wb_valid = r_valid;
    assign halted   = (r_state == c_HALTED);
    assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Purpose  : Scoreboard testbench for wb_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_reg_write = 1'b0;
    logic [3:0]  mem_dst_reg = 4'd0;
    logic        mem_to_reg = 1'b0;
    logic        mem_is_pcs = 1'b0;
    logic [15:0] mem_alu_result = 16'd0;
    logic [15:0] mem_read_data = 16'd0;
    logic [15:0] mem_pc_next = 16'd0;
    logic        mem_halt = 1'b0;
    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic        wb_valid;
    logic        halted;
    logic [15:0] retired;

    wb_stage #(.ZERO_REG_WRITE_EN(1'b0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_dst_reg(mem_dst_reg), .mem_to_reg(mem_to_reg),
        .mem_is_pcs(mem_is_pcs), .mem_alu_result(mem_alu_result),
        .mem_read_data(mem_read_data), .mem_pc_next(mem_pc_next),
        .mem_halt(mem_halt), .WriteReg(WriteReg), .DstReg(DstReg),
        .DstData(DstData), .wb_valid(wb_valid), .halted(halted),
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [3:0]  dst;
        logic [15:0] data;
        logic        valid;
        logic        hlt;
        logic [15:0] ret;
    } exp_t;

    exp_t sb[$];
    int   nTests = 0;
    int   nFail  = 0;

    // Reference model of the writeback register and control state.
    logic        mValid, mRegWrite, mToReg, mPcs, mHalt, mHalted;
    logic [3:0]  mDst;
    logic [15:0] mAlu, mRd, mPc, mRet;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelClear();
        mValid = 0; mRegWrite = 0; mToReg = 0; mPcs = 0; mHalt = 0; mHalted = 0;
        mDst = 0; mAlu = 0; mRd = 0; mPc = 0; mRet = 0;
    endtask

    function automatic exp_t modelOut();
        exp_t e;
        e.wr    = mValid & mRegWrite & ~mHalted & ~mHalt & (mDst != 4'd0);
        e.dst   = mDst;
        e.data  = mToReg ? mRd : (mPcs ? mPc : mAlu);
        e.valid = mValid;
        e.hlt   = mHalted;
        e.ret   = mRet;
        return e;
    endfunction

    task automatic step(input logic st, input logic fl, input logic v, input logic rw,
                        input logic [3:0] d, input logic tr, input logic pcs,
                        input logic [15:0] alu, input logic [15:0] rd,
                        input logic [15:0] pc, input logic h, input logic verify);
        logic haltNow;
        @(negedge clk);
        stall = st; flush = fl; mem_valid = v; mem_reg_write = rw; mem_dst_reg = d;
        mem_to_reg = tr; mem_is_pcs = pcs; mem_alu_result = alu;
        mem_read_data = rd; mem_pc_next = pc; mem_halt = h;
        if (!mHalted) begin
            haltNow = mValid && mHalt && !st;
            if (mValid && !mHalt && !st && mRet != 16'hFFFF) mRet = mRet + 16'd1;
            if (fl) mValid = 0;
            else if (!st && !haltNow) begin
                mValid = v; mRegWrite = rw; mDst = d; mToReg = tr; mPcs = pcs;
                mAlu = alu; mRd = rd; mPc = pc; mHalt = h & v;
            end
            if (haltNow) mHalted = 1;
        end
        if (verify) sb.push_back(modelOut());
        @(posedge clk);
        #1;
    endtask

    task automatic checkOut(input string tag);
        exp_t e;
        check({tag, "_sb"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_wr"},    WriteReg, e.wr);
            check({tag, "_dst"},   DstReg,   e.dst);
            check({tag, "_data"},  DstData,  e.data);
            check({tag, "_valid"}, wb_valid, e.valid);
            check({tag, "_halt"},  halted,   e.hlt);
            check({tag, "_ret"},   retired,  e.ret);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 0; stall = 0; flush = 0; mem_valid = 0; mem_halt = 0;
        modelClear();
        sb.delete();
        #12;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic idle(input logic verify);
        step(0, 0, 0, 0, 4'd0, 0, 0, 16'd0, 16'd0, 16'd0, 0, verify);
    endtask

    initial begin
        modelClear();
        #3;
        check("rst_wr",    WriteReg, 0);
        check("rst_dst",   DstReg,   0);
        check("rst_data",  DstData,  0);
        check("rst_valid", wb_valid, 0);
        check("rst_halt",  halted,   0);
        check("rst_ret",   retired,  0);
        doReset();

        // ALU writeback
        step(0, 0, 1, 1, 4'd3, 0, 0, 16'h1234, 16'h0, 16'h0, 0, 1);
        checkOut("alu");
        check("alu_lit_data", DstData, 16'h1234);
        check("alu_lit_wr", WriteReg, 1);
        // load, then PCS
        step(0, 0, 1, 1, 4'd5, 1, 0, 16'h0004, 16'hBEEF, 16'h0, 0, 1);
        checkOut("load");
        check("load_lit_data", DstData, 16'hBEEF);
        check("alu_lit_ret", retired, 1);
        step(0, 0, 1, 1, 4'd6, 0, 1, 16'h0055, 16'h0, 16'h0022, 0, 1);
        checkOut("pcs");
        check("pcs_lit_data", DstData, 16'h0022);
        // destination zero
        step(0, 0, 1, 1, 4'd0, 0, 0, 16'h7777, 16'h0, 16'h0, 0, 1);
        checkOut("zero");
        check("zero_lit_wr", WriteReg, 0);
        idle(1);
        checkOut("zero_ret");
        check("zero_lit_ret", retired, 4);
        // flush together with stall
        step(0, 0, 1, 1, 4'd2, 0, 0, 16'h1111, 16'h0, 16'h0, 0, 1);
        checkOut("pre_flush");
        step(1, 1, 1, 1, 4'd4, 0, 0, 16'h2222, 16'h0, 16'h0, 0, 1);
        checkOut("flush");
        check("flush_lit_valid", wb_valid, 0);
        // three-cycle stall with a held write
        step(0, 0, 1, 1, 4'd7, 0, 0, 16'hA5A5, 16'h0, 16'h0, 0, 1);
        checkOut("stall0");
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 1, 4'(8 + i), 1, 0, 16'($urandom), 16'($urandom), 16'h0, 0, 1);
            checkOut("stall");
            check("stall_lit_data", DstData, 16'hA5A5);
        end
        idle(1);
        checkOut("release");
        idle(1);
        checkOut("release2");
        // halt with valid=0 is ignored
        step(0, 0, 0, 0, 4'd0, 0, 0, 16'h0, 16'h0, 16'h0, 1, 1);
        checkOut("fakehlt");
        idle(1);
        checkOut("fakehlt2");
        check("fakehlt_lit", halted, 0);
        // HLT retires
        step(0, 0, 1, 0, 4'd0, 0, 0, 16'h0, 16'h0, 16'h0, 1, 1);
        checkOut("hlt");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 4'd9, 0, 0, 16'h3333, 16'h0, 16'h0, 0, 1);
            checkOut("halted");
        end
        check("halted_lit", halted, 1);
        check("halted_lit_wr", WriteReg, 0);
        // asynchronous reset between edges
        #2;
        rst = 0;
        #1;
        check("arst_wr",    WriteReg, 0);
        check("arst_data",  DstData,  0);
        check("arst_valid", wb_valid, 0);
        check("arst_halt",  halted,   0);
        check("arst_ret",   retired,  0);
        doReset();

        // retired saturation
        for (int i = 0; i < 65534; i++) begin
            step(0, 0, 1, 0, 4'd1, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        end
        check("sat_pre", retired, 16'hFFFD);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 4'd1, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1);
            checkOut("sat");
        end
        check("sat_lit", retired, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter ZERO_REG_WRITE_EN, default 0: when 0, writes targeting register 0 are suppressed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 stall  input  1  hold the MEM/WB register contents.
REQ-005 flush  input  1  load a bubble (valid=0) into the MEM/WB register.
REQ-006 mem_valid  input  1  MEM stage holds a real instruction.
REQ-007 mem_reg_write  input  1  instruction writes a register.
REQ-008 mem_dst_reg  input  4  destination register id.
REQ-009 mem_to_reg  input  1  select load data as the writeback value.
REQ-010 mem_is_pcs  input  1  select PC-next as the writeback value (PCS).
REQ-011 mem_alu_result  input  16  ALU result.
REQ-012 mem_read_data  input  16  data-memory load data.
REQ-013 mem_pc_next  input  16  PC+2 of the instruction.
REQ-014 mem_halt  input  1  instruction is HLT.
REQ-015 WriteReg  output  1  register-file write enable.
REQ-016 DstReg  output  4  register-file write address.
REQ-017 DstData  output  16  register-file write data.
REQ-018 wb_valid  output  1  MEM/WB register holds a valid instruction.
REQ-019 halted  output  1  processor halted.
REQ-020 retired  output  16  count of retired non-HLT instructions.

Function
REQ-021 MEM/WB register captures all mem_* inputs on each rising edge when state=RUN, flush=0 and stall=0.
REQ-022 flush=1 in RUN clears the registered valid bit at the edge; flush overrides stall.
REQ-023 stall=1 with flush=0 holds every registered field unchanged.
REQ-024 DstData is combinational from registered fields, with priority mem_to_reg, then mem_is_pcs, then alu_result.
REQ-025 WriteReg = wb_valid & reg_write & state=RUN & ~halt_r & (DstReg!=0 | ZERO_REG_WRITE_EN).
REQ-026 Latency: inputs sampled at edge N appear on DstReg/DstData/WriteReg after edge N, and the register file commits at edge N+1.
REQ-027 During stall the held instruction keeps WriteReg asserted; the repeated write of identical data is permitted.
REQ-028 FSM has two states, RUN and HALTED; reset state is RUN.
REQ-029 RUN to HALTED at the edge where wb_valid=1, halt_r=1 and stall=0; halted=1 from that edge.
REQ-030 HALTED is terminal until reset.
REQ-031 In HALTED: register inputs ignored, WriteReg=0, retired frozen.
REQ-032 retired increments by 1 at each edge where wb_valid=1, halt_r=0, stall=0 and state=RUN.
REQ-033 retired saturates at 0xFFFF and never wraps.
REQ-034 A stalled instruction is counted once: at the edge where stall is deasserted.
REQ-035 mem_halt with mem_valid=0 has no effect.

Reset
REQ-036 rst=0 immediately forces valid=0, all registered fields to 0, state=RUN, halted=0, retired=0, WriteReg=0, DstReg=0, DstData=0, regardless of clock.
REQ-037 Reset asserted mid-stall or mid-halt discards the in-flight instruction without a write.
REQ-038 First capture occurs at the first rising edge after rst rises.

Verification
REQ-039 Stimulus: ALU writeback, dst=3, alu=0x1234, valid=1, reg_write=1, to_reg=0, pcs=0. Response: after the edge, WriteReg=1, DstReg=3, DstData=0x1234; retired=1 after the next edge.
REQ-040 Stimulus: load, to_reg=1, read_data=0xBEEF, alu=0x0004. Response: DstData=0xBEEF. Stimulus: PCS with pc_next=0x0022. Response: DstData=0x0022.
REQ-041 Stimulus: dst=0 with ZERO_REG_WRITE_EN=0. Response: WriteReg=0, retired still increments. Stimulus: flush=1 together with stall=1. Response: wb_valid=0 next cycle.
REQ-042 Stimulus: stall for 3 cycles with a valid write held. Response: fields unchanged, retired increments exactly once after release.
REQ-043 Stimulus: HLT retires. Response: halted=1, later valid writes produce WriteReg=0, retired frozen; rst=0 mid-cycle clears everything asynchronously.
REQ-044 Stimulus: preload retired to 0xFFFE, then retire 3 instructions. Response: retired ends at 0xFFFF.
